// File: rtl/br_arb_rr_multi_grant.sv
// Round-robin arbiter granting up to NumGrants requesters per cycle, ordered by priority.
// Optional per-requester starvation flags under `BR_ARB_RR_MULTI_GRANT_STARVATION_EN.
module br_arb_rr_multi_grant #(
  parameter int NumRequesters = 2,
  parameter int NumGrants     = 1,
  parameter int MaxWait       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable_priority_update,
  input  logic [NumRequesters-1:0]                 request,
  output logic [NumGrants-1:0][NumRequesters-1:0]  grant_ordered,
  output logic [NumRequesters-1:0]                 grant,
  output logic [$clog2(NumGrants+1)-1:0]           grant_count,
  output logic [NumRequesters-1:0]                 starved
);

  localparam int N  = NumRequesters;
  localparam int G  = NumGrants;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(G + 1);
  localparam int RW = $clog2(N + 1);
  localparam logic [N-1:0] LpReset = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0]          lowest_prio;
  logic [IW-1:0]         lp_idx;
  logic [IW:0]           shamt;
  logic [2*N-1:0]        req_dbl;
  logic [N-1:0]          req_rot;
  logic [G-1:0][N-1:0]   rot_slot;
  logic [RW-1:0]         seen;
  logic [2*N-1:0]        slot_dbl;
  logic [N-1:0]          last_grant;

  always_comb begin
    lp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (lowest_prio[i]) lp_idx = IW'(i);
    end
  end

  // Rotate so bit 0 is the highest-priority requester (the one just above lowest_prio).
  assign shamt   = {1'b0, lp_idx} + (IW+1)'(1);
  assign req_dbl = {request, request} >> shamt;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    rot_slot = '0;
    seen     = '0;
    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < G; k++) begin
        if (req_rot[p] && (seen == RW'(k))) rot_slot[k][p] = 1'b1;
      end
      if (req_rot[p]) seen = seen + RW'(1);
    end
  end

  always_comb begin
    grant_ordered = '0;
    slot_dbl      = '0;
    for (int k = 0; k < G; k++) begin
      slot_dbl         = {rot_slot[k], rot_slot[k]} << shamt;
      grant_ordered[k] = slot_dbl[2*N-1:N];
    end
  end

  // Slots fill contiguously, so the last non-zero slot is the lowest-priority grant.
  always_comb begin
    grant       = '0;
    grant_count = '0;
    last_grant  = '0;
    for (int k = 0; k < G; k++) begin
      grant = grant | grant_ordered[k];
      if (|grant_ordered[k]) begin
        grant_count = grant_count + CW'(1);
        last_grant  = grant_ordered[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lowest_prio <= LpReset;
    end else if (enable_priority_update && (|request)) begin
      lowest_prio <= last_grant;
    end
  end

`ifdef BR_ARB_RR_MULTI_GRANT_STARVATION_EN
  localparam int WW = $clog2(MaxWait + 1);
  logic [WW-1:0] wait_cnt [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (request[i] && !grant[i]) begin
          if (wait_cnt[i] != WW'(MaxWait)) wait_cnt[i] <= wait_cnt[i] + WW'(1);
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < N; i++) starved[i] = (wait_cnt[i] == WW'(MaxWait));
  end

`ifndef SYNTHESIS
  for (genvar i = 0; i < N; i++) begin : g_wait_chk
    a_wait_bound: assert property (@(posedge clk) disable iff (rst) wait_cnt[i] <= WW'(MaxWait));
  end
`endif
`else
  assign starved = '0;
`endif

`ifndef SYNTHESIS
  a_params: assert property (@(posedge clk) (G >= 1) && (G <= N) && (N >= 2) && (MaxWait >= 1));
  a_req_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(request));
  a_lp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(lowest_prio));
  a_subset: assert property (@(posedge clk) disable iff (rst) (grant & ~request) == '0);
  a_disjoint: assert property (@(posedge clk) disable iff (rst) $countones(grant) == int'(grant_count));
  for (genvar k = 0; k < G; k++) begin : g_slot_chk
    a_slot_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_ordered[k]));
  end
`endif

endmodule
